segment_update_controller: RTL and testbench
============================================

SEGMENT_UPDATE_CONTROLLER -- requirements
Module: segment_update_controller

Interface
REQ-001 SHALL have parameter DATA_BITS, default 10, key length.
REQ-002 SHALL have parameter FRAGMENTS, default 5, number of fragments per key.
REQ-003 SHALL have parameter FRAG_BITS, default 3, fragment-index width.
REQ-004 SHALL have parameter TIMEOUT, default 255, max wait cycles for any handshake.
REQ-005 SHALL derive FRAG_WID=DATA_BITS/FRAGMENTS and ADDR_WID=FRAG_BITS+FRAG_WID.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_start  input  1  update request; honoured only in IDLE.
REQ-009 SHALL have port i_key  input  DATA_BITS  rule key; sampled on accepted i_start.
REQ-010 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse when all fragments have been written.
REQ-012 SHALL have port o_error  output  1  one-cycle pulse on timeout abort.
REQ-013 SHALL have port o_fragment_key  output  ADDR_WID  {fragment index, key slice} sent to the datapath address stage.
REQ-014 SHALL have ports o_sdram_read and o_sdram_write  output  1 each  SDRAM read and write requests.
REQ-015 SHALL have ports i_sdram_waitrequest and i_sdram_readdatavalid  input  1 each  SDRAM handshake inputs.
REQ-016 SHALL have port o_cntl_s0_modify  output  1  modify strobe to the datapath.
REQ-017 SHALL have port i_cntl_s0_modify_done  input  1  modify-complete from the datapath.

Function
REQ-018 SHALL latch i_key into an internal register on i_start in IDLE; i_start while busy SHALL be ignored.
REQ-019 SHALL set o_fragment_key for fragment f (0..FRAGMENTS-1, ascending) to {f[FRAG_BITS-1:0], key[f*FRAG_WID +: FRAG_WID]} and hold it stable until f advances.
REQ-020 SHALL implement FSM states IDLE, ADDR, RD_REQ, RD_WAIT, SETTLE, MODIFY, MOD_WAIT, WR_REQ, NEXT, and DONE.
REQ-021 SHALL transition IDLE->ADDR on accepted start with f=0.
REQ-022 SHALL stay in ADDR exactly 1 cycle, covering the registered address stage, then enter RD_REQ.
REQ-023 SHALL hold o_sdram_read high in RD_REQ until a cycle with i_sdram_waitrequest=0, then enter RD_WAIT.
REQ-024 SHALL leave RD_WAIT on i_sdram_readdatavalid=1 for SETTLE.
REQ-025 SHALL stay in SETTLE 1 cycle, covering the registered readdata stage, then enter MODIFY.
REQ-026 SHALL assert o_cntl_s0_modify for exactly 1 cycle in MODIFY, then enter MOD_WAIT.
REQ-027 SHALL leave MOD_WAIT for WR_REQ on i_cntl_s0_modify_done=1.
REQ-028 SHALL hold o_sdram_write high in WR_REQ until i_sdram_waitrequest=0, then enter NEXT.
REQ-029 SHALL, in NEXT, go to DONE if f==FRAGMENTS-1, else increment f and go to ADDR.
REQ-030 SHALL pulse o_done in DONE for 1 cycle and return to IDLE; a new start SHALL be accepted the following cycle.
REQ-031 SHALL clear a wait counter on entry to RD_REQ, RD_WAIT, MOD_WAIT, and WR_REQ, increment it each cycle in those states, and saturate it.
REQ-032 SHALL, when the counter reaches TIMEOUT, pulse o_error, drop all requests, and return to IDLE without o_done.
REQ-033 SHALL never assert o_sdram_read and o_sdram_write simultaneously.
REQ-034 SHALL treat i_cntl_s0_modify_done outside MOD_WAIT, and i_sdram_readdatavalid outside RD_WAIT, as don't-care.
REQ-035 SHALL give o_cntl_s0_modify, o_sdram_read, o_sdram_write, o_done, and o_error 1-cycle timing: registered outputs asserted in the cycle the FSM occupies the state.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, enter IDLE and clear f, counter, and latched key.
REQ-037 SHALL drive all outputs to 0 on reset, including o_fragment_key=0.
REQ-038 SHALL abort an update in progress on reset mid-operation with no o_done or o_error.
REQ-039 SHALL let reset take priority over i_start in the same cycle.

Verification
REQ-040 SHALL verify a normal update: i_key=10'h393, zero waitrequest, readdatavalid 2 cycles after read, modify_done 3 cycles after modify -> o_fragment_key sequence 5'h03, 5'h04, 5'h09, 5'h0E, 5'h13; 5 reads, 5 modify pulses, 5 writes; one o_done.
REQ-041 SHALL verify backpressure: waitrequest=1 for 4 cycles on each read/write -> read/write held 5 cycles each, address stable, same completion.
REQ-042 SHALL verify timeout: modify_done never asserted -> o_error pulse exactly TIMEOUT cycles after MOD_WAIT entry, o_busy=0 next cycle, no write issued.
REQ-043 SHALL verify start while busy: i_start with i_key=10'h3FF during fragment 2 -> ignored; remaining addresses still from 10'h393.
REQ-044 SHALL verify reset mid-operation: reset during WR_REQ of fragment 3 -> all outputs 0 next cycle, no o_done; new start with 10'h000 -> addresses 5'h00, 5'h04, 5'h08, 5'h0C, 5'h10.
REQ-045 SHALL verify back-to-back updates: i_start asserted the cycle after o_done -> accepted; second update completes correctly.

Source files
------------

// File: rtl/segment_update_controller_if.sv
// Request and handshake bundle between an update requester and segment_update_controller.
// The controller connects through the slave modport, the requester or bench through the master modport.
interface segment_update_controller_if #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_WID  = 5
);
  logic                 i_start;
  logic [DATA_BITS-1:0] i_key;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [ADDR_WID-1:0]  o_fragment_key;
  logic                 o_sdram_read;
  logic                 o_sdram_write;
  logic                 i_sdram_waitrequest;
  logic                 i_sdram_readdatavalid;
  logic                 o_cntl_s0_modify;
  logic                 i_cntl_s0_modify_done;

  modport master (
    output i_start, i_key, i_sdram_waitrequest, i_sdram_readdatavalid, i_cntl_s0_modify_done,
    input  o_busy, o_done, o_error, o_fragment_key, o_sdram_read, o_sdram_write, o_cntl_s0_modify
  );

  modport slave (
    input  i_start, i_key, i_sdram_waitrequest, i_sdram_readdatavalid, i_cntl_s0_modify_done,
    output o_busy, o_done, o_error, o_fragment_key, o_sdram_read, o_sdram_write, o_cntl_s0_modify
  );
endinterface

// File: rtl/segment_update_controller.sv
// Runs each key fragment through SDRAM read, datapath modify and SDRAM write; all outputs registered.
// Each handshake stalls on waitrequest/valid/done for up to TIMEOUT cycles, then aborts with an o_error pulse.
module segment_update_controller #(
  parameter int DATA_BITS = 10,
  parameter int FRAGMENTS = 5,
  parameter int FRAG_BITS = 3,
  parameter int TIMEOUT   = 255
) (
  input logic                        clk,
  input logic                        reset,
  segment_update_controller_if.slave bus
);
  localparam int FRAG_WID = DATA_BITS / FRAGMENTS;
  localparam int ADDR_WID = FRAG_BITS + FRAG_WID;
  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [FRAG_BITS-1:0] LAST_FRAG = FRAG_BITS'(FRAGMENTS - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_WARN  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, RD_REQ, RD_WAIT, SETTLE, MODIFY, MOD_WAIT, WR_REQ, NEXT, DONE
  } state_t;

  state_t               state;
  logic [FRAG_BITS-1:0] frag;
  logic [FRAG_BITS-1:0] frag_nxt;
  logic [DATA_BITS-1:0] key_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 hs_ok;

  assign frag_nxt = frag + 1'b1;

  function automatic logic [ADDR_WID-1:0] frag_addr(input logic [DATA_BITS-1:0] k,
                                                    input logic [FRAG_BITS-1:0] f);
    return {f, k[f*FRAG_WID +: FRAG_WID]};
  endfunction

  // Completion condition of whichever handshake the current wait state is blocked on.
  always_comb begin
    hs_ok = 1'b0;
    case (state)
      RD_REQ:   hs_ok = !bus.i_sdram_waitrequest;
      RD_WAIT:  hs_ok = bus.i_sdram_readdatavalid;
      MOD_WAIT: hs_ok = bus.i_cntl_s0_modify_done;
      WR_REQ:   hs_ok = !bus.i_sdram_waitrequest;
      default:  hs_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      frag                 <= '0;
      key_q                <= '0;
      wait_cnt             <= '0;
      bus.o_busy           <= 1'b0;
      bus.o_done           <= 1'b0;
      bus.o_error          <= 1'b0;
      bus.o_fragment_key   <= '0;
      bus.o_sdram_read     <= 1'b0;
      bus.o_sdram_write    <= 1'b0;
      bus.o_cntl_s0_modify <= 1'b0;
    end else begin
      bus.o_done           <= 1'b0;
      bus.o_error          <= 1'b0;
      bus.o_cntl_s0_modify <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            key_q              <= bus.i_key;
            frag               <= '0;
            bus.o_fragment_key <= frag_addr(bus.i_key, '0);
            bus.o_busy         <= 1'b1;
            state              <= ADDR;
          end
        end
        ADDR: begin
          bus.o_sdram_read <= 1'b1;
          wait_cnt         <= '0;
          state            <= RD_REQ;
        end
        RD_REQ, RD_WAIT, MOD_WAIT, WR_REQ: begin
          // The o_error cycle is spent in the wait state with requests already dropped.
          if (wait_cnt == CNT_MAX) begin
            bus.o_busy <= 1'b0;
            state      <= IDLE;
          end else if (hs_ok) begin
            wait_cnt          <= '0;
            bus.o_sdram_read  <= 1'b0;
            bus.o_sdram_write <= (state == MOD_WAIT);
            case (state)
              RD_REQ:   state <= RD_WAIT;
              RD_WAIT:  state <= SETTLE;
              MOD_WAIT: state <= WR_REQ;
              default:  state <= NEXT;
            endcase
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_WARN) begin
              bus.o_error       <= 1'b1;
              bus.o_sdram_read  <= 1'b0;
              bus.o_sdram_write <= 1'b0;
            end
          end
        end
        SETTLE: begin
          bus.o_cntl_s0_modify <= 1'b1;
          state                <= MODIFY;
        end
        MODIFY: begin
          wait_cnt <= '0;
          state    <= MOD_WAIT;
        end
        NEXT: begin
          if (frag == LAST_FRAG) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end else begin
            frag               <= frag_nxt;
            bus.o_fragment_key <= frag_addr(key_q, frag_nxt);
            state              <= ADDR;
          end
        end
        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_segment_update_controller.sv
// Bench for segment_update_controller: behavioural SDRAM/datapath responder plus directed and random updates.
`timescale 1ns/1ps
module tb_segment_update_controller;
  localparam int DATA_BITS = 10;
  localparam int FRAGMENTS = 5;
  localparam int FRAG_BITS = 3;
  localparam int TIMEOUT   = 255;
  localparam int FRAG_WID  = DATA_BITS / FRAGMENTS;
  localparam int ADDR_WID  = FRAG_BITS + FRAG_WID;
  localparam logic [ADDR_WID-1:0] ADDR_393 [FRAGMENTS] = '{5'h03, 5'h04, 5'h09, 5'h0E, 5'h13};
  localparam logic [ADDR_WID-1:0] ADDR_000 [FRAGMENTS] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  segment_update_controller_if #(.DATA_BITS(DATA_BITS), .ADDR_WID(ADDR_WID)) bus ();

  segment_update_controller #(
    .DATA_BITS(DATA_BITS), .FRAGMENTS(FRAGMENTS), .FRAG_BITS(FRAG_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Responder configuration, written only by the test tasks.
  int wait_n = 0, rv_delay = 2, md_delay = 3;
  bit md_never = 0, noise = 0;

  // Monitor state, written only by the responder/monitor process.
  int cyc = 0, rd_age = 0, wr_age = 0, rv_cnt = 0, md_cnt = 0;
  int overlap = 0, err_req = 0, unstable = 0;
  int mod_cnt = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int last_mod_cyc = 0, err_cyc = 0, rd_first_cyc = 0;
  logic [ADDR_WID-1:0] rd_addr0;
  logic [ADDR_WID-1:0] rd_q[$];
  int rd_len_q[$];
  int wr_len_q[$];

  function automatic int exp_addr(input int key, input int f);
    return (f << FRAG_WID) | ((key >> (f * FRAG_WID)) & ((1 << FRAG_WID) - 1));
  endfunction

  function automatic logic [ADDR_WID-1:0] rd_at(input int i);
    return (i < rd_q.size()) ? rd_q[i] : '1;
  endfunction

  function automatic int len_at(input int q_sel, input int i);
    if (q_sel == 0) return (i < rd_len_q.size()) ? rd_len_q[i] : -1;
    return (i < wr_len_q.size()) ? wr_len_q[i] : -1;
  endfunction

  // SDRAM + datapath responder and protocol monitor, evaluated once per cycle at the falling edge.
  initial begin
    bus.i_sdram_waitrequest   = 1'b0;
    bus.i_sdram_readdatavalid = 1'b0;
    bus.i_cntl_s0_modify_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_sdram_read && bus.o_sdram_write) overlap++;
      if (bus.o_error && (bus.o_sdram_read || bus.o_sdram_write)) err_req++;
      if (bus.o_done) done_cnt++;
      if (bus.o_error) begin err_cnt++; err_cyc = cyc; end
      bus.i_sdram_readdatavalid = 1'b0;
      if (rv_cnt > 0) begin rv_cnt--; if (rv_cnt == 0) bus.i_sdram_readdatavalid = 1'b1; end
      bus.i_cntl_s0_modify_done = 1'b0;
      if (md_cnt > 0) begin md_cnt--; if (md_cnt == 0) bus.i_cntl_s0_modify_done = 1'b1; end
      if (bus.o_cntl_s0_modify) begin
        mod_cnt++;
        last_mod_cyc = cyc;
        if (!md_never) md_cnt = md_delay;
        if (noise) bus.i_cntl_s0_modify_done = 1'($urandom);
      end
      bus.i_sdram_waitrequest = noise ? 1'($urandom) : 1'b0;
      if (bus.o_sdram_read) begin
        if (rd_age == 0) begin rd_first_cyc = cyc; rd_addr0 = bus.o_fragment_key; end
        else if (bus.o_fragment_key !== rd_addr0) unstable++;
        if (noise) bus.i_sdram_readdatavalid = 1'($urandom);
        bus.i_sdram_waitrequest = (rd_age < wait_n);
        if (rd_age >= wait_n) begin
          rd_q.push_back(bus.o_fragment_key);
          rd_len_q.push_back(rd_age + 1);
          rv_cnt = rv_delay;
          rd_age = 0;
        end else rd_age++;
      end else rd_age = 0;
      if (bus.o_sdram_write) begin
        if (rd_q.size() == 0 || bus.o_fragment_key !== rd_q[$]) unstable++;
        bus.i_sdram_waitrequest = (wr_age < wait_n);
        if (wr_age >= wait_n) begin
          wr_cnt++;
          wr_len_q.push_back(wr_age + 1);
          wr_age = 0;
        end else wr_age++;
      end else wr_age = 0;
    end
  end

  task automatic start_update(input logic [DATA_BITS-1:0] k);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_key   = k;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_key   = DATA_BITS'($urandom);
  endtask

  task automatic wait_end(output bit expired);
    expired = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_error) begin expired = 1'b0; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [ADDR_WID+5:0] outs;
    reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_key = '0;
    repeat (3) @(negedge clk);
    outs = {bus.o_busy, bus.o_done, bus.o_error, bus.o_sdram_read, bus.o_sdram_write,
            bus.o_cntl_s0_modify, bus.o_fragment_key};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    bus.i_start = 1'b1;
    bus.i_key = 10'h3FF;
    @(negedge clk);
    reset = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy: got %b want 0", bus.o_busy); end
    checks++;
    if (bus.o_fragment_key !== '0) begin errors++; $display("FAIL reset_priority_key: got %h want 0", bus.o_fragment_key); end
  endtask

  task automatic test_normal();
    int r0, w0, m0, d0, e0;
    bit exp;
    wait_n = 0; rv_delay = 2; md_delay = 3; md_never = 0; noise = 0;
    r0 = rd_q.size(); w0 = wr_cnt; m0 = mod_cnt; d0 = done_cnt; e0 = err_cnt;
    start_update(10'h393);
    wait_end(exp);
    checks++; if (exp) begin errors++; $display("FAIL normal_finish: got no end within budget want o_done"); end
    checks++; if (rd_q.size() - r0 != 5) begin errors++; $display("FAIL normal_reads: got %0d want 5", rd_q.size() - r0); end
    checks++; if (wr_cnt - w0 != 5) begin errors++; $display("FAIL normal_writes: got %0d want 5", wr_cnt - w0); end
    checks++; if (mod_cnt - m0 != 5) begin errors++; $display("FAIL normal_modify_cycles: got %0d want 5", mod_cnt - m0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL normal_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL normal_error: got %0d want 0", err_cnt - e0); end
    for (int f = 0; f < FRAGMENTS; f++) begin
      checks++;
      if (rd_at(r0 + f) !== ADDR_393[f]) begin
        errors++; $display("FAIL normal_addr[%0d]: got %h want %h", f, rd_at(r0 + f), ADDR_393[f]);
      end
    end
  endtask

  task automatic test_backpressure();
    int r0, l0, wl0, d0, u0;
    bit exp;
    wait_n = 4; rv_delay = 2; md_delay = 3;
    r0 = rd_q.size(); l0 = rd_len_q.size(); wl0 = wr_len_q.size(); d0 = done_cnt; u0 = unstable;
    start_update(10'h393);
    wait_end(exp);
    checks++; if (exp || done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt - d0); end
    checks++; if (unstable != u0) begin errors++; $display("FAIL bp_addr_stable: got %0d changes want 0", unstable - u0); end
    for (int f = 0; f < FRAGMENTS; f++) begin
      checks++;
      if (rd_at(r0 + f) !== ADDR_393[f]) begin errors++; $display("FAIL bp_addr[%0d]: got %h want %h", f, rd_at(r0 + f), ADDR_393[f]); end
      checks++;
      if (len_at(0, l0 + f) != 5) begin errors++; $display("FAIL bp_read_hold[%0d]: got %0d want 5", f, len_at(0, l0 + f)); end
      checks++;
      if (len_at(1, wl0 + f) != 5) begin errors++; $display("FAIL bp_write_hold[%0d]: got %0d want 5", f, len_at(1, wl0 + f)); end
    end
    wait_n = 0;
  endtask

  task automatic test_timeout();
    int w0, d0, e0, q0;
    bit exp;
    md_never = 1;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; q0 = err_req;
    start_update(10'h393);
    wait_end(exp);
    checks++; if (exp || err_cnt - e0 != 1) begin errors++; $display("FAIL to_error: got %0d pulses want 1", err_cnt - e0); end
    checks++; if (err_cyc - (last_mod_cyc + 1) != TIMEOUT) begin
      errors++; $display("FAIL to_latency: got %0d want %0d", err_cyc - (last_mod_cyc + 1), TIMEOUT); end
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL to_no_write: got %0d want 0", wr_cnt - w0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL to_no_done: got %0d want 0", done_cnt - d0); end
    checks++; if (err_req != q0) begin errors++; $display("FAIL to_req_dropped: got %0d want 0", err_req - q0); end
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL to_busy_after: got %b want 0", bus.o_busy); end
    md_never = 0;
  endtask

  task automatic test_read_timeout();
    int r0, e0, q0;
    bit exp;
    wait_n = 100000;
    r0 = rd_q.size(); e0 = err_cnt; q0 = err_req;
    start_update(10'h155);
    wait_end(exp);
    checks++; if (exp || err_cnt - e0 != 1) begin errors++; $display("FAIL rto_error: got %0d pulses want 1", err_cnt - e0); end
    checks++; if (err_cyc - rd_first_cyc != TIMEOUT) begin
      errors++; $display("FAIL rto_latency: got %0d want %0d", err_cyc - rd_first_cyc, TIMEOUT); end
    checks++; if (rd_q.size() != r0 || err_req != q0) begin
      errors++; $display("FAIL rto_read_dropped: got accepts=%0d overlap=%0d want 0 0", rd_q.size() - r0, err_req - q0); end
    wait_n = 0;
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rto_busy_after: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_start_busy();
    int r0, d0;
    bit seen, exp;
    r0 = rd_q.size(); d0 = done_cnt; seen = 1'b0;
    start_update(10'h393);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (rd_q.size() >= r0 + 3) begin seen = 1'b1; break; end
    end
    bus.i_start = 1'b1;
    bus.i_key = 10'h3FF;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_end(exp);
    checks++; if (!seen || exp || done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
    checks++; if (rd_q.size() - r0 != 5) begin errors++; $display("FAIL busy_start_reads: got %0d want 5", rd_q.size() - r0); end
    for (int f = 0; f < FRAGMENTS; f++) begin
      checks++;
      if (rd_at(r0 + f) !== ADDR_393[f]) begin errors++; $display("FAIL busy_start_addr[%0d]: got %h want %h", f, rd_at(r0 + f), ADDR_393[f]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_reset_mid();
    int r0, d0, e0;
    bit hit, exp;
    logic [ADDR_WID+5:0] outs;
    r0 = rd_q.size(); d0 = done_cnt; e0 = err_cnt; hit = 1'b0;
    start_update(10'h393);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (rd_q.size() == r0 + 4 && bus.o_sdram_write) begin hit = 1'b1; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    outs = {bus.o_busy, bus.o_done, bus.o_error, bus.o_sdram_read, bus.o_sdram_write,
            bus.o_cntl_s0_modify, bus.o_fragment_key};
    checks++; if (!hit || outs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0 (hit=%0d)", outs, hit); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL midreset_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    r0 = rd_q.size();
    start_update(10'h000);
    wait_end(exp);
    checks++; if (exp || done_cnt - d0 != 1) begin errors++; $display("FAIL midreset_restart_done: got %0d want 1", done_cnt - d0); end
    for (int f = 0; f < FRAGMENTS; f++) begin
      checks++;
      if (rd_at(r0 + f) !== ADDR_000[f]) begin errors++; $display("FAIL midreset_addr[%0d]: got %h want %h", f, rd_at(r0 + f), ADDR_000[f]); end
    end
  endtask

  task automatic test_back_to_back();
    int r0, d0;
    bit got, exp;
    logic [DATA_BITS-1:0] k1, k2;
    k1 = DATA_BITS'($urandom); k2 = DATA_BITS'($urandom);
    r0 = rd_q.size(); d0 = done_cnt; got = 1'b0;
    start_update(k1);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.o_done) begin got = 1'b1; break; end
    end
    @(negedge clk);
    checks++; if (!got || bus.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b done_seen=%0d want 0 1", bus.o_busy, got); end
    bus.i_start = 1'b1;
    bus.i_key = k2;
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_fragment_key !== ADDR_WID'(exp_addr(k2, 0))) begin
      errors++; $display("FAIL b2b_first_addr: got %h want %h", bus.o_fragment_key, exp_addr(k2, 0)); end
    wait_end(exp);
    checks++; if (exp || done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
    for (int f = 0; f < FRAGMENTS; f++) begin
      checks++;
      if (rd_at(r0 + 5 + f) !== ADDR_WID'(exp_addr(k2, f))) begin
        errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", f, rd_at(r0 + 5 + f), exp_addr(k2, f)); end
    end
  endtask

  task automatic test_random();
    int r0, l0, wl0, w0, d0, e0;
    bit exp;
    logic [DATA_BITS-1:0] k;
    for (int it = 0; it < 6; it++) begin
      k = DATA_BITS'($urandom);
      wait_n = $urandom_range(0, 3);
      rv_delay = $urandom_range(1, 4);
      md_delay = $urandom_range(1, 4);
      noise = 1;
      r0 = rd_q.size(); l0 = rd_len_q.size(); wl0 = wr_len_q.size();
      w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
      start_update(k);
      wait_end(exp);
      checks++; if (exp || done_cnt - d0 != 1 || err_cnt != e0) begin
        errors++; $display("FAIL rand%0d_end: got done=%0d err=%0d want 1 0", it, done_cnt - d0, err_cnt - e0); end
      checks++; if (rd_q.size() - r0 != 5 || wr_cnt - w0 != 5) begin
        errors++; $display("FAIL rand%0d_counts: got rd=%0d wr=%0d want 5 5", it, rd_q.size() - r0, wr_cnt - w0); end
      for (int f = 0; f < FRAGMENTS; f++) begin
        checks++;
        if (rd_at(r0 + f) !== ADDR_WID'(exp_addr(k, f))) begin
          errors++; $display("FAIL rand%0d_addr[%0d]: got %h want %h", it, f, rd_at(r0 + f), exp_addr(k, f)); end
        checks++;
        if (len_at(0, l0 + f) != wait_n + 1 || len_at(1, wl0 + f) != wait_n + 1) begin
          errors++; $display("FAIL rand%0d_hold[%0d]: got rd=%0d wr=%0d want %0d", it, f, len_at(0, l0 + f), len_at(1, wl0 + f), wait_n + 1); end
      end
    end
    noise = 0;
    wait_n = 0;
  endtask

  task automatic test_invariants();
    #1;
    checks++; if (overlap != 0) begin errors++; $display("FAIL rw_exclusive: got %0d overlap cycles want 0", overlap); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL addr_stable: got %0d changes want 0", unstable); end
    checks++; if (err_req != 0) begin errors++; $display("FAIL error_drops_req: got %0d want 0", err_req); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_timeout();
    test_read_timeout();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
